// File: rtl/pl_hazard_ctl.sv
// Pipeline hazard control: forwarding select, load-use / MDU stall, branch squash.
// Define HAZ_STATS_EN to add saturating stall_cnt_o / flush_cnt_o counters.
module pl_hazard_ctl #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [REG_AW-1:0] ern_i,
  input  logic [REG_AW-1:0] mrn_i,
  input  logic              ewreg_i,
  input  logic              em2reg_i,
  input  logic              mwreg_i,
  input  logic              mm2reg_i,
  input  logic              id_jump_i,
  input  logic              id_mdu_i,
  input  logic              id_hilo_i,
  output logic [1:0]        fwda_o,
  output logic [1:0]        fwdb_o,
  output logic              wpcir_o,
  output logic              bubble_o,
  output logic              ebubble_o,
  output logic              mdu_busy_o,
`ifdef HAZ_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic              mdu_done_o
);

  localparam logic [3:0] LAT = 4'(MDU_LAT);

  logic       ex_alu, mem_alu, mem_ld;
  logic       load_use, mdu_haz, stall;
  logic       ebubble_q, ebubble_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic       mdu_done_q, mdu_done_d;
  logic       issue;

  // Register 0 is hardwired, so it never qualifies as a forwarding source.
  assign ex_alu  = ewreg_i & ~em2reg_i & (ern_i != '0);
  assign mem_alu = mwreg_i & ~mm2reg_i & (mrn_i != '0);
  assign mem_ld  = mwreg_i &  mm2reg_i & (mrn_i != '0);

  always_comb begin
    fwda_o = 2'b00;
    if (ex_alu && ern_i == rs_i)       fwda_o = 2'b01;
    else if (mem_alu && mrn_i == rs_i) fwda_o = 2'b10;
    else if (mem_ld && mrn_i == rs_i)  fwda_o = 2'b11;
  end

  always_comb begin
    fwdb_o = 2'b00;
    if (ex_alu && ern_i == rt_i)       fwdb_o = 2'b01;
    else if (mem_alu && mrn_i == rt_i) fwdb_o = 2'b10;
    else if (mem_ld && mrn_i == rt_i)  fwdb_o = 2'b11;
  end

  assign load_use = ewreg_i & em2reg_i & (ern_i != '0) &
                    ((use_rs_i & (ern_i == rs_i)) |
                     (use_rt_i & (ern_i == rt_i)));
  assign mdu_haz  = (id_mdu_i | id_hilo_i) & mdu_busy_o;
  assign stall    = (load_use | mdu_haz) & ~ebubble_q;

  assign wpcir_o    = ~stall;
  assign bubble_o   = stall | ebubble_q;
  assign ebubble_o  = ebubble_q;
  assign mdu_busy_o = (mdu_cnt_q != 4'd0);
  assign mdu_done_o = mdu_done_q;

  assign issue      = id_mdu_i & ~stall & ~ebubble_q;
  assign ebubble_d  = id_jump_i & ~stall & ~ebubble_q;
  assign mdu_done_d = (mdu_cnt_q == 4'd1);

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue)                mdu_cnt_d = LAT;
    else if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ebubble_q  <= 1'b0;
      mdu_cnt_q  <= 4'd0;
      mdu_done_q <= 1'b0;
    end else begin
      ebubble_q  <= ebubble_d;
      mdu_cnt_q  <= mdu_cnt_d;
      mdu_done_q <= mdu_done_d;
    end
  end

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ebubble_q && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pl_hazard_ctl.sv
// Bench for pl_hazard_ctl: directed vector table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_pl_hazard_ctl;

  localparam int LAT  = 4;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, ern, mrn;
  logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
  logic       id_jump, id_mdu, id_hilo;
  logic [1:0] fwda, fwdb;
  logic       wpcir, bubble, ebubble, mdu_busy, mdu_done;
`ifdef HAZ_STATS_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pl_hazard_ctl #(.REG_AW(5), .MDU_LAT(LAT), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs_i(rs), .rt_i(rt), .use_rs_i(use_rs), .use_rt_i(use_rt),
    .ern_i(ern), .mrn_i(mrn),
    .ewreg_i(ewreg), .em2reg_i(em2reg),
    .mwreg_i(mwreg), .mm2reg_i(mm2reg),
    .id_jump_i(id_jump), .id_mdu_i(id_mdu), .id_hilo_i(id_hilo),
    .fwda_o(fwda), .fwdb_o(fwdb), .wpcir_o(wpcir),
    .bubble_o(bubble), .ebubble_o(ebubble),
    .mdu_busy_o(mdu_busy),
`ifdef HAZ_STATS_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .mdu_done_o(mdu_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_ebub;
  int m_rem;
  bit m_done;
  int m_sc, m_fc;

  typedef struct {
    int rs, rt, urs, urt, ern, mrn, ew, el, mw, ml;
    int fa, fb, st;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int r);
    if (r == 0) return 2'b00;
    if (ewreg && !em2reg && int'(ern) == r) return 2'b01;
    if (mwreg && !mm2reg && int'(mrn) == r) return 2'b10;
    if (mwreg && mm2reg && int'(mrn) == r) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit ref_stall();
    bit lu, mh;
    lu = ewreg && em2reg && ern != 0 &&
         ((use_rs && ern == rs) || (use_rt && ern == rt));
    mh = (id_mdu || id_hilo) && m_rem > 0;
    return (lu || mh) && !m_ebub;
  endfunction

  task automatic model_reset();
    m_ebub = 0; m_rem = 0; m_done = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic clr_in();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
    id_jump = 0; id_mdu = 0; id_hilo = 0;
  endtask

  task automatic step();
    bit st, nd, iss;
    @(negedge clk);
    st = ref_stall();
    check("fwda", 16'(fwda), 16'(ref_fwd(int'(rs))));
    check("fwdb", 16'(fwdb), 16'(ref_fwd(int'(rt))));
    check("wpcir", 16'(wpcir), 16'(!st));
    check("bubble", 16'(bubble), 16'(st || m_ebub));
    check("ebubble", 16'(ebubble), 16'(m_ebub));
    check("mdu_busy", 16'(mdu_busy), 16'(m_rem > 0));
    check("mdu_done", 16'(mdu_done), 16'(m_done));
`ifdef HAZ_STATS_EN
    check("stall_cnt", 16'(stall_cnt), 16'(m_sc));
    check("flush_cnt", 16'(flush_cnt), 16'(m_fc));
`endif
    @(posedge clk);
    iss = id_mdu && !st && !m_ebub;
    nd  = (m_rem == 1);
    if (iss) m_rem = LAT;
    else if (m_rem > 0) m_rem--;
    m_done = nd;
    if (st && m_sc < CMAX) m_sc++;
    if (m_ebub && m_fc < CMAX) m_fc++;
    m_ebub = id_jump && !st && !m_ebub;
    #1;
  endtask

  initial begin
    int busyc, stallc, donec;
    //        rs rt urs urt ern mrn ew el mw ml  fa fb st
    vt[0] = '{3, 0, 1, 0, 3, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[1] = '{3, 0, 1, 0, 0, 3, 0, 0, 1, 1, 3, 0, 0};
    vt[2] = '{1, 5, 1, 1, 5, 5, 1, 0, 1, 0, 0, 1, 0};
    vt[3] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    vt[4] = '{2, 7, 1, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0};
    vt[5] = '{9, 9, 1, 1, 9, 9, 1, 0, 1, 0, 1, 1, 0};
    vt[6] = '{6, 4, 1, 1, 4, 6, 1, 0, 1, 0, 2, 1, 0};
    vt[7] = '{8, 8, 1, 1, 8, 8, 0, 0, 1, 1, 3, 3, 0};

    clr_in();
    rst = 1'b1;
    #12;
    check("rst_ebubble", 16'(ebubble), 16'd0);
    check("rst_busy", 16'(mdu_busy), 16'd0);
    check("rst_done", 16'(mdu_done), 16'd0);
`ifdef HAZ_STATS_EN
    check("rst_stall_cnt", 16'(stall_cnt), 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    foreach (vt[i]) begin
      rs = 5'(vt[i].rs); rt = 5'(vt[i].rt);
      use_rs = vt[i].urs[0]; use_rt = vt[i].urt[0];
      ern = 5'(vt[i].ern); mrn = 5'(vt[i].mrn);
      ewreg = vt[i].ew[0]; em2reg = vt[i].el[0];
      mwreg = vt[i].mw[0]; mm2reg = vt[i].ml[0];
      #1;
      check($sformatf("vec%0d_fwda", i), 16'(fwda), 16'(vt[i].fa));
      check($sformatf("vec%0d_fwdb", i), 16'(fwdb), 16'(vt[i].fb));
      check($sformatf("vec%0d_wpcir", i), 16'(wpcir), 16'(vt[i].st == 0));
      check($sformatf("vec%0d_bubble", i), 16'(bubble), 16'(vt[i].st));
    end

    // restart cleanly so statistics match the model
    clr_in();
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // load-use stall then load-data forwarding from MEM
    ern = 3; ewreg = 1; em2reg = 1; rs = 3; use_rs = 1;
    step();
    ern = 0; ewreg = 0; em2reg = 0; mrn = 3; mwreg = 1; mm2reg = 1;
    step();

    // branch squash, jump held through the squash cycle
    clr_in();
    id_jump = 1;
    step();
    check("jump_squash", 16'(ebubble), 16'd1);
    step();
    id_jump = 0;
    check("jump_no_retrigger", 16'(ebubble), 16'd0);
    step();

    // MDU issue, then HI/LO read waits for completion
    clr_in();
    id_mdu = 1;
    step();
    id_mdu = 0; id_hilo = 1;
    busyc = 0; stallc = 0; donec = 0;
    repeat (7) begin
      busyc  += int'(mdu_busy);
      stallc += int'(!wpcir);
      donec  += int'(mdu_done);
      step();
    end
    check("mdu_busy_cycles", 16'(busyc), 16'd4);
    check("mdu_stall_cycles", 16'(stallc), 16'd4);
    check("mdu_done_pulses", 16'(donec), 16'd1);
    check("mdu_release_wpcir", 16'(wpcir), 16'd1);

    // reset in the middle of an MDU operation
    clr_in();
    id_mdu = 1;
    step();
    id_mdu = 0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 16'(mdu_busy), 16'd0);
`ifdef HAZ_STATS_EN
    check("abort_stall_cnt", 16'(stall_cnt), 16'd0);
`endif
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    donec = 0;
    repeat (6) begin
      donec += int'(mdu_done);
      step();
    end
    check("abort_no_done", 16'(donec), 16'd0);

    // long load-use stall drives the counter into saturation
    ern = 2; ewreg = 1; em2reg = 1; rs = 2; use_rs = 1;
    repeat (20) step();
`ifdef HAZ_STATS_EN
    check("stall_cnt_sat", 16'(stall_cnt), 16'd15);
`endif

    repeat (400) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      ewreg = 1'($urandom); em2reg = 1'($urandom);
      mwreg = 1'($urandom); mm2reg = 1'($urandom);
      id_jump = ($urandom_range(0, 7) == 0);
      id_mdu  = ($urandom_range(0, 9) == 0);
      id_hilo = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pl_hazard_ctl.md
PL_HAZARD_CTL -- requirements
Module: pl_hazard_ctl

Interface
REQ-001 SHALL have parameter REG_AW, 5, register-number width.
REQ-002 SHALL have parameter MDU_LAT, 4, multiply/divide busy cycles after issue (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, 16, statistics counter width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rs, rt  in  REG_AW each  ID-stage source register numbers.
REQ-007 use_rs, use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-008 ern, mrn  in  REG_AW each  EX / MEM destination register numbers.
REQ-009 ewreg, em2reg, mwreg, mm2reg  in  1 each  EX / MEM register-write and load flags.
REQ-010 id_jump  in  1  ID instruction is a resolved taken branch or jump.
REQ-011 id_mdu, id_hilo  in  1 each  ID instruction starts the MDU / reads HI/LO.
REQ-012 fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
REQ-013 wpcir  out  1  PC and IF/ID write enable.
REQ-014 bubble  out  1  zero all ID control signals entering EX.
REQ-015 ebubble  out  1  current ID instruction is squashed.
REQ-016 mdu_busy, mdu_done  out  1 each  MDU in flight / one-cycle completion pulse.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  statistics (present only under HAZ_STATS_EN).

Function
REQ-018 fwda SHALL be 01 when ewreg & ~em2reg & ern!=0 & ern==rs; else 10 when mwreg & ~mm2reg & mrn!=0 & mrn==rs; else 11 when mwreg & mm2reg & mrn!=0 & mrn==rs; else 00.
REQ-019 fwdb SHALL follow REQ-018 with rt replacing rs; EX match always has priority over MEM match.
REQ-020 Register 0 SHALL never produce forwarding or stall.
REQ-021 load_use SHALL be ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)); unused operands never stall.
REQ-022 mdu_haz SHALL be (id_mdu | id_hilo) & mdu_busy.
REQ-023 stall SHALL be (load_use | mdu_haz) & ~ebubble; wpcir = ~stall; bubble = stall | ebubble.
REQ-024 ebubble SHALL be a register loaded each cycle with id_jump & ~stall & ~ebubble; a squashed instruction never re-triggers squash.
REQ-025 MDU counter (4 bits) SHALL load MDU_LAT when id_mdu & ~stall & ~ebubble, else decrement if nonzero; mdu_busy = counter!=0.
REQ-026 mdu_done SHALL pulse high for exactly the cycle after the counter transitions 1->0 (registered).
REQ-027 A new MDU issue is impossible while busy (REQ-022), so counter reload on a nonzero value SHALL never occur.
REQ-028 Simultaneous load_use and mdu_haz SHALL produce one stall cycle per cycle, not two.
REQ-029 fwda/fwdb SHALL remain combinational and valid during stall and bubble cycles.

Reset
REQ-030 On reset SHALL clear ebubble, MDU counter, mdu_done, stall_cnt, flush_cnt to 0 immediately, independent of clock.
REQ-031 Reset asserted mid-MDU-operation SHALL abort it: mdu_busy 0 and no mdu_done pulse afterwards.
REQ-032 After reset release, first edge SHALL behave as normal operation with no residual squash.

Configuration
REQ-033 Macro HAZ_STATS_EN defined: stall_cnt increments each cycle stall=1, flush_cnt each cycle ebubble=1, both saturating at all-ones.
REQ-034 Macro HAZ_STATS_EN undefined: stall_cnt and flush_cnt ports and logic absent; all other behaviour identical.

Verification
REQ-035 ern=3, ewreg=1, em2reg=1, rs=3, use_rs=1 -> wpcir=0, bubble=1, fwda=00 for one cycle; next cycle mrn=3, mm2reg=1 -> fwda=11, wpcir=1.
REQ-036 ern=5 (ALU), mrn=5 (ALU), rt=5, use_rt=1 -> fwdb=01; ern=0, mrn=0, rs=0 -> fwda=00, no stall.
REQ-037 id_jump=1 one cycle -> ebubble=1 and bubble=1 next cycle only; id_jump held high during that squash cycle -> ebubble 0 the cycle after.
REQ-038 MDU_LAT=4, id_mdu pulse, then id_hilo=1 held -> mdu_busy 4 cycles, wpcir=0 for 4 cycles, mdu_done pulses once, then wpcir=1.
REQ-039 reset asserted two cycles into MDU operation -> mdu_busy=0 immediately, no mdu_done pulse, stall_cnt=0.
REQ-040 HAZ_STATS_EN with CNT_W=4, 20 continuous stall cycles -> stall_cnt saturates at 15.
